// File: rtl/fp_pkg.sv
// Shared definitions for the integer-to-float converter: float field layout,
// default exponent bias and the converter FSM state type.
package fp_pkg;

    localparam int INT_W        = 32;
    localparam int SIGN_W       = 1;
    localparam int EXP_W        = 6;
    localparam int FRAC_W       = 25;
    localparam int EXP_BIAS_DEF = 31;

    localparam int SIGN_POS = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 25;
    localparam int FRAC_HI  = 24;
    localparam int FRAC_LO  = 0;

    // Bits of the normalised magnitude dropped below the fraction field.
    localparam int GUARD_W = INT_W - SIGN_W - FRAC_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } conv_state_t;

    function automatic logic [INT_W-1:0] fp_pack(
        input logic              sign,
        input logic [EXP_W-1:0]  exponent,
        input logic [FRAC_W-1:0] fraction
    );
        return {sign, exponent, fraction};
    endfunction

endpackage

// File: rtl/int_to_fp_conv.sv
// Iterative signed 32-bit integer to 32-bit float converter (truncating).
// Normalisation shifts the magnitude one bit per cycle until its MSB is set.
module int_to_fp_conv
    import fp_pkg::*;
#(
    parameter int EXP_BIAS = EXP_BIAS_DEF
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic [1:0]  status_out
);

    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + INT_W - 1);

    conv_state_t            state_r;
    conv_state_t            next_state_s;
    logic [INT_W-1:0]       operand_r;
    logic                   sign_r;
    logic [INT_W-1:0]       mag_r;
    logic [EXP_W-1:0]       shift_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [INT_W-1:0]       data_out_r;
    logic [1:0]             status_out_r;

    logic                   accept_s;
    logic [INT_W-1:0]       abs_mag_s;
    logic [EXP_W-1:0]       exp_s;
    logic [FRAC_W-1:0]      frac_s;
    logic                   inexact_s;
    logic                   zero_s;

    assign accept_s = in_valid && in_ready_r;

    // Magnitude of the captured operand; 0x80000000 maps onto itself.
    always_comb begin
        abs_mag_s = operand_r;
        if (operand_r[SIGN_POS]) begin
            abs_mag_s = ~operand_r + 32'd1;
        end else begin
            abs_mag_s = operand_r;
        end
    end

    // Field extraction from the normalised magnitude for packing.
    always_comb begin
        exp_s     = EXP_TOP - shift_r;
        frac_s    = mag_r[INT_W-2:GUARD_W];
        inexact_s = |mag_r[GUARD_W-1:0];
        zero_s    = ~mag_r[INT_W-1];
    end

    // FSM state register.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = ABS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ABS: begin
                if (abs_mag_s == 32'd0) begin
                    next_state_s = PACK;
                end else begin
                    next_state_s = NORM;
                end
            end
            NORM: begin
                if (mag_r[INT_W-1]) begin
                    next_state_s = PACK;
                end else begin
                    next_state_s = NORM;
                end
            end
            PACK: begin
                next_state_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Operand capture, magnitude normalisation and result packing.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            operand_r    <= 32'd0;
            sign_r       <= 1'b0;
            mag_r        <= 32'd0;
            shift_r      <= 6'd0;
            data_out_r   <= 32'd0;
            status_out_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        operand_r <= int_in;
                    end else begin
                        operand_r <= operand_r;
                    end
                end
                ABS: begin
                    sign_r  <= operand_r[SIGN_POS];
                    mag_r   <= abs_mag_s;
                    shift_r <= 6'd0;
                end
                NORM: begin
                    if (!mag_r[INT_W-1]) begin
                        mag_r   <= {mag_r[INT_W-2:0], 1'b0};
                        shift_r <= shift_r + 6'd1;
                    end else begin
                        mag_r   <= mag_r;
                        shift_r <= shift_r;
                    end
                end
                PACK: begin
                    // A zero magnitude never normalises, so an unset MSB means zero.
                    if (zero_s) begin
                        data_out_r   <= 32'd0;
                        status_out_r <= 2'b10;
                    end else begin
                        data_out_r   <= fp_pack(sign_r, exp_s, frac_s);
                        status_out_r <= {1'b0, inexact_s};
                    end
                end
                default: begin
                    data_out_r <= data_out_r;
                end
            endcase
        end
    end

    // Handshake flags registered from the next state so they track state_r.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign data_out   = data_out_r;
    assign status_out = status_out_r;

endmodule

// File: tb/tb_int_to_fp_conv.sv
// Self-checking bench for int_to_fp_conv: directed corner values, random
// operands against an arithmetic reference model, hold and mid-run reset.
module tb_int_to_fp_conv;

    logic        clock_100kHz;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [1:0]  status_out;

    int checks;
    int errors;

    int_to_fp_conv #(.EXP_BIAS(31)) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .int_in       (int_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    initial clock_100kHz = 1'b0;
    always #5 clock_100kHz = ~clock_100kHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // value = (-1)^s * 1.f * 2^(e-31), truncated; latency = leading zeros + 3.
    task automatic ref_conv(input logic [31:0] v, output logic [31:0] d,
                            output logic [1:0] st, output int lat);
        longint x, mag, rem, scaled, one_p;
        int p;
        logic [24:0] frac;
        logic [5:0] e;
        x   = longint'($signed(v));
        mag = (x < 64'sd0) ? -x : x;
        if (mag == 64'sd0) begin
            d = 32'd0; st = 2'b10; lat = 2;
        end else begin
            p = 0;
            while ((64'sd1 <<< (p + 1)) <= mag) p++;
            one_p  = 64'sd1 <<< p;
            rem    = mag - one_p;
            scaled = rem <<< 25;
            frac   = 25'(scaled / one_p);
            e      = 6'(31 + p);
            d      = {(x < 64'sd0), e, frac};
            st     = {1'b0, (scaled % one_p) != 64'sd0};
            lat    = (31 - p) + 3;
        end
    endtask

    task automatic convert(input logic [31:0] v, input logic [31:0] exp_d,
                           input logic [1:0] exp_st, input int exp_lat, input int hold);
        int cycles;
        @(negedge clock_100kHz);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        int_in   = v;
        in_valid = 1'b1;
        @(posedge clock_100kHz);
        #1;
        // Junk operands and early out_ready must be ignored while busy.
        int_in    = $urandom;
        out_ready = 1'b1;
        cycles    = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clock_100kHz);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 32'(cycles), 32'(exp_lat));
        chk("data_out", data_out, exp_d);
        chk("status_out", {30'd0, status_out}, {30'd0, exp_st});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        repeat (hold) @(posedge clock_100kHz);
        #1;
        if (hold > 0) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", data_out, exp_d);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            chk("still_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clock_100kHz);
        #1;
        out_ready = 1'b0;
        chk("released_valid", {31'd0, out_valid}, 32'd0);
        chk("released_ready", {31'd0, in_ready}, 32'd1);
        chk("retained_data", data_out, exp_d);
    endtask

    initial begin
        logic [31:0] v, md;
        logic [1:0]  ms;
        int          ml;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        int_in    = 32'd0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_status", {30'd0, status_out}, 32'd0);
        @(negedge clock_100kHz);
        reset = 1'b1;

        convert(32'h0000_0001, 32'h3E00_0000, 2'b00, 34, 0);
        convert(32'h8000_0000, 32'hFC00_0000, 2'b00, 3, 0);
        convert(32'h0000_0000, 32'h0000_0000, 2'b10, 2, 0);
        convert(32'h7FFF_FFFF, 32'h7BFF_FFFF, 2'b01, 4, 10);
        convert(32'hFFFF_FFFB, 32'hC280_0000, 2'b00, 32, 1);

        // Reset pulse while normalising a small operand.
        @(negedge clock_100kHz);
        int_in   = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clock_100kHz);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock_100kHz);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", data_out, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock_100kHz);
        reset = 1'b1;
        convert(32'hFFFF_FFFB, 32'hC280_0000, 2'b00, 32, 0);

        for (int i = 0; i < 24; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            ref_conv(v, md, ms, ml);
            convert(v, md, ms, ml, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
